id_ex_stage: RTL

//  ID/EX pipeline stage directly downstream of the register file. Captures rs/rt read data, immediate and control.

---
 rtl/id_ex_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with $0 read forcing, load-use hazard stall (LOAD_STALL bubbles) and flush.
// Optional `WB_BYPASS_EN: same-cycle writeback data is bypassed into the captured operands.
module id_ex_stage #(
    parameter int CTRL_W     = 8,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dst,
    input  logic              id_uses_rt,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [31:0]       wb_write_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write
);
    localparam int CNT_W = $clog2(LOAD_STALL + 1);

    typedef enum logic {RUN, STALL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             haz;
    logic [31:0]      rs_op;
    logic [31:0]      rt_op;

    // The register file never resets entry 0, so $0 must be forced here.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rs_op = id_rs_data;
        rt_op = id_rt_data;
`ifdef WB_BYPASS_EN
        if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == id_rs) rs_op = wb_write_data;
        if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == id_rt) rt_op = wb_write_data;
`endif
        if (id_rs == 5'd0) rs_op = 32'h0;
        if (id_rt == 5'd0) rt_op = 32'h0;
    end

`ifndef WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_write_reg, wb_write_data};
`endif

    assign haz = id_valid & ex_valid & ex_mem_read & (ex_dst != 5'd0) &
                 ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

    assign stall = !flush && (state == STALL || haz);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dst       <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (flush) begin
            state        <= RUN;
            cnt          <= '0;
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (state == STALL) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            cnt          <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= RUN;
        end else if (haz) begin
            // Bubbles only clear the qualifiers; the data fields keep their old values.
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            if (LOAD_STALL > 1) begin
                state <= STALL;
                cnt   <= CNT_W'(LOAD_STALL - 1);
            end
        end else begin
            ex_valid     <= id_valid;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_reg_write <= id_valid & id_reg_write;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_dst       <= id_dst;
            ex_rs_data   <= rs_op;
            ex_rt_data   <= rt_op;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
        end
    end
endmodule
